enc8to3_pending: RTL and testbench



---
 rtl/enc8to3_pending.sv | 85 ++++++++
 tb/tb_enc8to3_pending.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/enc8to3_pending.sv
// enc8to3_pending: sticky 8-bit request capture with a fixed-priority
// 8-to-3 encode, presented one index at a time over valid/ready.
module enc8to3_pending (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ready,
    output logic       valid,
    output logic [2:0] code,
    output logic [7:0] pending,
    output logic       busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_n;
    logic [7:0] pend_q;
    logic [7:0] pend_n;
    logic [7:0] clr_mask;
    logic [2:0] code_q;
    logic [2:0] code_n;
    logic [2:0] enc;

    // Fixed-priority encode of the pending register, bit 7 wins.
    always_comb begin
        enc = 3'd0;
        priority case (1'b1)
            pend_q[7]: enc = 3'd7;
            pend_q[6]: enc = 3'd6;
            pend_q[5]: enc = 3'd5;
            pend_q[4]: enc = 3'd4;
            pend_q[3]: enc = 3'd3;
            pend_q[2]: enc = 3'd2;
            pend_q[1]: enc = 3'd1;
            pend_q[0]: enc = 3'd0;
            default:   enc = 3'd0;
        endcase
    end

    // Next state, latched code and the accept clear mask.
    always_comb begin
        state_n  = state_q;
        code_n   = code_q;
        clr_mask = 8'h00;
        case (state_q)
            IDLE: begin
                if (pend_q != 8'h00) begin
                    code_n  = enc;
                    state_n = PRESENT;
                end
            end
            PRESENT: begin
                if (ready) begin
                    clr_mask = 8'h01 << code_q;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        pend_n = (pend_q & ~clr_mask) | req;
    end

    // State, code and pending registers; new requests override the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= 3'd0;
            pend_q  <= 8'h00;
        end else begin
            state_q <= state_n;
            code_q  <= code_n;
            pend_q  <= pend_n;
        end
    end

    assign valid   = (state_q == PRESENT);
    assign code    = code_q;
    assign pending = pend_q;
    assign busy    = valid | (|pend_q);

endmodule

// File: tb/tb_enc8to3_pending.sv
// tb_enc8to3_pending: directed vectors with hand-computed expectations
// for the sticky-request priority encoder.
module tb_enc8to3_pending;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       ready;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pending;
    logic       busy;

    int nvec;
    int nerr;

    enc8to3_pending dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ready   (ready),
        .valid   (valid),
        .code    (code),
        .pending (pending),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [2:0] c, input logic [7:0] p,
                           input logic b);
        chk({tag, ".valid"}, 8'(valid), 8'(v));
        if (v)
            chk({tag, ".code"}, 8'(code), 8'(c));
        chk({tag, ".pending"}, pending, p);
        chk({tag, ".busy"}, 8'(busy), 8'(b));
    endtask

    initial begin
        logic [2:0] exp_codes [4];
        logic       was_acc;
        logic [2:0] acc_code;
        int         nacc;
        int         cyc;

        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        req   = 8'h00;
        ready = 1'b0;

        // Reset state.
        #2;
        chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
        chk("reset.code", 8'(code), 8'h00);
        step();
        #2 rst_n = 1'b1;
        step();
        chk_out("idle", 1'b0, 3'd0, 8'h00, 1'b0);

        // Single request: one valid cycle with code 3.
        req   = 8'h08;
        ready = 1'b1;
        step();
        req = 8'h00;
        chk_out("single.k", 1'b0, 3'd0, 8'h08, 1'b1);
        step();
        chk_out("single.k1", 1'b1, 3'd3, 8'h08, 1'b1);
        step();
        chk_out("single.acc", 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        chk_out("single.after", 1'b0, 3'd0, 8'h00, 1'b0);

        // Priority order 7,5,2,0 with an idle cycle between each.
        exp_codes[0] = 3'd7;
        exp_codes[1] = 3'd5;
        exp_codes[2] = 3'd2;
        exp_codes[3] = 3'd0;
        req = 8'hA5;
        step();
        req = 8'h00;
        chk("prio.load", pending, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("prio.valid", 8'(valid), 8'h01);
            chk("prio.code", 8'(code), 8'(exp_codes[i]));
            step();
            chk("prio.gap", 8'(valid), 8'h00);
        end
        chk_out("prio.end", 1'b0, 3'd0, 8'h00, 1'b0);

        // Hold stability while a higher request arrives.
        ready = 1'b0;
        req   = 8'h01;
        step();
        req = 8'h00;
        step();
        chk_out("hold.first", 1'b1, 3'd0, 8'h01, 1'b1);
        for (int i = 0; i < 5; i++) begin
            req = (i % 2 == 0) ? 8'h80 : 8'h00;
            step();
            chk("hold.valid", 8'(valid), 8'h01);
            chk("hold.code", 8'(code), 8'h00);
        end
        req = 8'h00;
        chk("hold.pend", pending, 8'h81);
        ready = 1'b1;
        step();
        chk_out("hold.acc", 1'b0, 3'd0, 8'h80, 1'b1);
        step();
        chk_out("hold.next", 1'b1, 3'd7, 8'h80, 1'b1);
        step();
        chk_out("hold.end", 1'b0, 3'd0, 8'h00, 1'b0);

        // Set wins over clear on the accepted bit.
        ready = 1'b0;
        req   = 8'h10;
        step();
        req = 8'h00;
        step();
        chk_out("swc.pres", 1'b1, 3'd4, 8'h10, 1'b1);
        ready = 1'b1;
        req   = 8'h10;
        step();
        req   = 8'h00;
        ready = 1'b0;
        chk_out("swc.acc", 1'b0, 3'd0, 8'h10, 1'b1);
        step();
        chk_out("swc.again", 1'b1, 3'd4, 8'h10, 1'b1);
        ready = 1'b1;
        step();
        chk_out("swc.end", 1'b0, 3'd0, 8'h00, 1'b0);

        // Full load with random ready: eight accepts, 7 down to 0.
        ready = 1'b0;
        req   = 8'hFF;
        step();
        req = 8'h00;
        chk("full.load", pending, 8'hFF);
        nacc = 0;
        cyc  = 0;
        while (nacc < 8 && cyc < 200) begin
            ready    = 1'($urandom_range(0, 1));
            was_acc  = valid & ready;
            acc_code = code;
            step();
            cyc++;
            if (was_acc) begin
                chk("full.code", 8'(acc_code), 8'(7 - nacc));
                nacc++;
            end
        end
        chk("full.count", 8'(nacc), 8'd8);
        chk_out("full.end", 1'b0, 3'd0, 8'h00, 1'b0);
        ready = 1'b0;

        // Reset mid-handshake drops everything asynchronously.
        req = 8'hC0;
        step();
        req = 8'h00;
        step();
        chk_out("rst.pres", 1'b1, 3'd7, 8'hC0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 3'd0, 8'h00, 1'b0);
        chk("rst.code", 8'(code), 8'h00);
        step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("rst.after", 1'b0, 3'd0, 8'h00, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
